fma_issue_arbiter: RTL and testbench

Shares one floating-point fused multiply-add datapath between NUM_REQ requesters. Each request carries a (A, B, C, rnd) operand set. Requests are granted round-robin and issued through registered operand ports into the FMA unit, which has a fixed latency. Results are tagged with the requester ID, buffered in a response FIFO, and returned on a single valid/ready response port. Issue is credit-gated, so the FIFO can never overflow.

---
 rtl/fma_issue_arbiter.sv | 154 +++++++++++++++
 tb/tb_fma_issue_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_issue_arbiter.sv
// rtl/fma_issue_arbiter.sv - round-robin issue of operand sets into a shared FMA with a credit-gated response FIFO
module fma_issue_arbiter #(
  parameter int WIDTH      = 32,
  parameter int NUM_REQ    = 4,
  parameter int IDW        = 2,
  parameter int FMA_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*WIDTH-1:0] req_c,
  input  logic [NUM_REQ*2-1:0]   req_rnd,
  output logic [WIDTH-1:0]       fma_a,
  output logic [WIDTH-1:0]       fma_b,
  output logic [WIDTH-1:0]       fma_c,
  output logic [1:0]             fma_rnd,
  output logic                   fma_in_valid,
  input  logic [WIDTH-1:0]       fma_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gidx;
  logic [IDW-1:0] cand;
  logic           found;
  logic           accept;
  logic [CW-1:0]  credits;
  logic [IDW-1:0] fma_id;
  logic           push_v;
  logic [IDW-1:0] push_id;
  logic           pop;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  // Reset also masks the grant so nothing is offered while rst is held low.
  assign req_ready = (rst && found && credits != '0) ? (NUM_REQ'(1) << gidx) : '0;
  assign accept    = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr       <= '0;
      fma_a        <= '0;
      fma_b        <= '0;
      fma_c        <= '0;
      fma_rnd      <= '0;
      fma_id       <= '0;
      fma_in_valid <= 1'b0;
    end else begin
      fma_in_valid <= accept;
      if (accept) begin
        fma_a   <= req_a[gidx*WIDTH +: WIDTH];
        fma_b   <= req_b[gidx*WIDTH +: WIDTH];
        fma_c   <= req_c[gidx*WIDTH +: WIDTH];
        fma_rnd <= req_rnd[gidx*2 +: 2];
        fma_id  <= gidx;
        if (gidx == IDW'(NUM_REQ - 1)) rr_ptr <= '0;
        else                           rr_ptr <= gidx + IDW'(1);
      end
    end
  end

  // Tags ride alongside the non-stallable FMA so each result lands with its owner.
  generate
    if (FMA_LAT == 0) begin : g_comb
      assign push_v  = fma_in_valid;
      assign push_id = fma_id;
    end else begin : g_pipe
      logic [FMA_LAT-1:0]          pipe_v;
      logic [FMA_LAT-1:0][IDW-1:0] pipe_id;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pipe_v  <= '0;
          pipe_id <= '0;
        end else begin
          pipe_v[0]  <= fma_in_valid;
          pipe_id[0] <= fma_id;
          for (int j = 1; j < FMA_LAT; j++) begin
            pipe_v[j]  <= pipe_v[j-1];
            pipe_id[j] <= pipe_id[j-1];
          end
        end
      end
      assign push_v  = pipe_v[FMA_LAT-1];
      assign push_id = pipe_id[FMA_LAT-1];
    end
  endgenerate

  logic [WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [IDW-1:0]   mem_id   [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [IDW-1:0]   last_id;
  logic [WIDTH-1:0] last_data;

  assign rsp_valid = (wr_ptr != rd_ptr);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr[AW-1:0]]   : last_id;
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr[AW-1:0]] : last_data;

  always_ff @(posedge clk) begin
    if (push_v) begin
      mem_data[wr_ptr[AW-1:0]] <= fma_result;
      mem_id[wr_ptr[AW-1:0]]   <= push_id;
    end
  end

  // Credits already reserved a slot for every in-flight op, so push never checks for full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_id   <= '0;
      last_data <= '0;
      credits   <= CW'(FIFO_DEPTH);
    end else begin
      if (push_v) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_id   <= mem_id[rd_ptr[AW-1:0]];
        last_data <= mem_data[rd_ptr[AW-1:0]];
      end
      case ({accept, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  assign busy = (credits != CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_fma_issue_arbiter.sv
// tb/tb_fma_issue_arbiter.sv - directed self-checking bench for fma_issue_arbiter
module tb_fma_issue_arbiter;
  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready;
  logic [W-1:0]   ra [N], rb [N], rc [N];
  logic [1:0]     rr [N];
  logic [N*W-1:0] req_a, req_b, req_c;
  logic [N*2-1:0] req_rnd;
  logic [W-1:0]   fma_a, fma_b, fma_c, fma_result;
  logic [1:0]     fma_rnd;
  logic           fma_in_valid, rsp_valid, rsp_ready, busy;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;

  always_comb begin
    req_a = '0; req_b = '0; req_c = '0; req_rnd = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W]  = ra[i];
      req_b[i*W +: W]  = rb[i];
      req_c[i*W +: W]  = rc[i];
      req_rnd[i*2 +: 2] = rr[i];
    end
  end

  fma_issue_arbiter #(.WIDTH(W), .NUM_REQ(N), .IDW(2), .FMA_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_rnd(req_rnd),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_rnd(fma_rnd),
    .fma_in_valid(fma_in_valid), .fma_result(fma_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  // Two-stage FMA stand-in: the 1*2+3 vector yields 5.0, anything else a^b^c.
  function automatic logic [W-1:0] fma_model(input logic [W-1:0] a, b, c);
    if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h40400000) return 32'h40A00000;
    return a ^ b ^ c;
  endfunction

  logic [W-1:0] p1, p2;
  always @(posedge clk) begin
    p1 <= fma_model(fma_a, fma_b, fma_c);
    p2 <= p1;
  end
  assign fma_result = p2;

  int n_tests = 0;
  int n_fail  = 0;
  int q_id [$];
  logic [W-1:0] q_d [$];
  logic acc;
  int n_acc, n_iss, g;
  logic [15:0] pat;
  int fair_exp [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic take_rsp(input string tag);
    if (rsp_valid && rsp_ready) begin
      if (q_id.size() == 0) chk({tag, "_spurious"}, rsp_valid, 0);
      else begin
        chk({tag, "_id"}, rsp_id, q_id[0]);
        chk({tag, "_data"}, rsp_data, q_d[0]);
        void'(q_id.pop_front());
        void'(q_d.pop_front());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      ra[i] = 32'h1000_0000; rb[i] = '0; rc[i] = W'(i); rr[i] = 2'b10;
    end
    pat = 16'b0011_1010_0110_1101;
    repeat (2) @(negedge clk);

    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fma_in_valid", fma_in_valid, 0);
    rst = 1'b1;
    step();

    // single request from requester 2
    ra[2] = 32'h3F800000; rb[2] = 32'h40000000; rc[2] = 32'h40400000; rr[2] = 2'b01;
    req_valid = 4'b0100;
    #1 chk("t1_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    chk("t1_in_valid", fma_in_valid, 1);
    chk("t1_fma_a", fma_a, 32'h3F800000);
    chk("t1_fma_b", fma_b, 32'h40000000);
    chk("t1_fma_c", fma_c, 32'h40400000);
    chk("t1_fma_rnd", fma_rnd, 2'b01);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_in_valid_drop", fma_in_valid, 0);
    chk("t1_rsp_early1", rsp_valid, 0);
    step();
    chk("t1_rsp_early2", rsp_valid, 0);
    step();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 2);
    chk("t1_rsp_data", rsp_data, 32'h40A00000);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t1_popped", rsp_valid, 0);
    chk("t1_busy_clear", busy, 0);
    chk("t1_hold_id", rsp_id, 2);
    chk("t1_hold_data", rsp_data, 32'h40A00000);
    ra[2] = 32'h1000_0000; rb[2] = '0; rc[2] = 32'd2; rr[2] = 2'b10;

    // all four valid: pointer is 3 after the first grant
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    g = 3; n_iss = 0;
    for (int cyc = 0; cyc < 60 && n_iss < 12; cyc++) begin
      #1;
      if (req_ready != '0) begin
        chk("rr_grant", req_ready, 64'(1) << g);
        q_id.push_back(g);
        q_d.push_back(ra[g] ^ rb[g] ^ rc[g]);
        g = (g + 1) % N;
        n_iss++;
      end
      take_rsp("rr");
      step();
    end
    req_valid = '0;
    for (int cyc = 0; cyc < 20 && q_id.size() != 0; cyc++) begin
      take_rsp("rr");
      step();
    end
    chk("rr_issued", n_iss, 12);
    chk("rr_drained", q_id.size(), 0);
    chk("rr_busy", busy, 0);

    // backpressure: requester 0 streams with rsp_ready low
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    rc[0] = 32'h100;
    n_acc = 0;
    repeat (10) begin
      #1;
      acc = req_ready[0];
      if (acc) begin
        n_acc++;
        q_id.push_back(0);
        q_d.push_back(ra[0] ^ rb[0] ^ rc[0]);
      end
      step();
      if (acc) rc[0] = rc[0] + 1;
    end
    #1;
    chk("bp_accepts", n_acc, 4);
    chk("bp_stalled", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_busy", busy, 1);
    chk("bp_head_data", rsp_data, 32'h1000_0100);
    rsp_ready = 1'b1;
    take_rsp("bp");
    step();
    rsp_ready = 1'b0;
    #1 chk("bp_reenable", req_ready, 4'b0001);
    q_id.push_back(0);
    q_d.push_back(ra[0] ^ rb[0] ^ rc[0]);
    step();
    rc[0] = rc[0] + 1;
    #1 chk("bp_only_one", req_ready, 0);

    // ragged rsp_ready while streaming: FIFO pointers wrap several times
    for (int cyc = 0; cyc < 300 && !(rc[0] >= 32'h110 && q_id.size() == 0); cyc++) begin
      rsp_ready = pat[cyc % 16];
      req_valid = (rc[0] < 32'h110) ? 4'b0001 : 4'b0000;
      #1;
      acc = req_valid[0] & req_ready[0];
      if (acc) begin
        q_id.push_back(0);
        q_d.push_back(ra[0] ^ rb[0] ^ rc[0]);
      end
      take_rsp("wrap");
      step();
      if (acc) rc[0] = rc[0] + 1;
    end
    rsp_ready = 1'b0;
    req_valid = '0;
    chk("wrap_count", rc[0], 32'h110);
    chk("wrap_left", q_id.size(), 0);
    chk("wrap_busy", busy, 0);

    // fairness: get the pointer to 2, then requesters 1 and 3 compete
    rsp_ready = 1'b1;
    fair_exp = '{3, 1, 3};
    req_valid = 4'b0010;
    #1 chk("fair_pre", req_ready, 4'b0010);
    q_id.push_back(1);
    q_d.push_back(ra[1] ^ rb[1] ^ rc[1]);
    take_rsp("fair");
    step();
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fair_grant", req_ready, 64'(1) << fair_exp[i]);
      q_id.push_back(fair_exp[i]);
      q_d.push_back(ra[fair_exp[i]] ^ rb[fair_exp[i]] ^ rc[fair_exp[i]]);
      take_rsp("fair");
      step();
    end
    req_valid = '0;
    repeat (8) begin
      take_rsp("fair");
      step();
    end
    chk("fair_drained", q_id.size(), 0);

    // async reset with two ops in flight and two buffered
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    n_acc = 0;
    for (int i = 0; i < 12 && n_acc < 4; i++) begin
      #1;
      if (req_ready[0]) n_acc++;
      step();
    end
    step();
    #1 chk("rr_pre_rsp_valid", rsp_valid, 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_fma_in_valid", fma_in_valid, 0);
    chk("arst_busy", busy, 0);
    req_valid = '0;
    q_id.delete();
    q_d.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      #1 chk("arst_stale", rsp_valid, 0);
      step();
    end
    req_valid = 4'b1001;
    #1 chk("arst_ptr0", req_ready, 4'b0001);
    q_id.push_back(0);
    q_d.push_back(ra[0] ^ rb[0] ^ rc[0]);
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) begin
      take_rsp("post");
      step();
    end
    chk("post_drained", q_id.size(), 0);
    chk("post_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
